// File: rtl/s_pipe_reg.sv
// DEPTH-deep, SIZE-wide pipeline register with valid/ready flow control,
// bubble collapsing, synchronous flush and a registered occupancy count.
module s_pipe_reg #(
    parameter int unsigned     SIZE    = 8,
    parameter int unsigned     DEPTH   = 4,
    parameter logic [SIZE-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       ivld,
    output logic                       irdy,
    input  logic [SIZE-1:0]            idat,
    output logic                       ovld,
    input  logic                       ordy,
    output logic [SIZE-1:0]            odat,
    output logic [$clog2(DEPTH+1)-1:0] occ
);

    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_nxt;
    logic [DEPTH-1:0] load_ok;
    logic [DEPTH-1:0] move;
    logic [SIZE-1:0]  dat [DEPTH];
    logic [OW-1:0]    occ_nxt;
    logic             take;

    // Ready ripples back from the output: a stage frees up if its content moves on.
    always_comb begin
        load_ok = '0;
        move    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            int unsigned i;
            i = DEPTH - 1 - k;
            if (i == DEPTH - 1)
                move[i] = vld[i] & ordy;
            else
                move[i] = vld[i] & load_ok[i+1];
            load_ok[i] = ~vld[i] | move[i];
        end
    end

    assign irdy = load_ok[0] & ~flush;
    assign take = ivld & irdy;

    always_comb begin
        vld_nxt = vld;
        occ_nxt = '0;
        if (take)
            vld_nxt[0] = 1'b1;
        else if (move[0])
            vld_nxt[0] = 1'b0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (move[i-1])
                vld_nxt[i] = 1'b1;
            else if (move[i])
                vld_nxt[i] = 1'b0;
        end
        if (flush)
            vld_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            occ_nxt = occ_nxt + OW'(vld_nxt[i]);
    end

    // Data shifts are suppressed during flush so odat holds its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            occ <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                dat[i] <= RST_VAL;
        end else begin
            vld <= vld_nxt;
            occ <= occ_nxt;
            if (!flush) begin
                if (take)
                    dat[0] <= idat;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    if (move[i-1])
                        dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign ovld = vld[DEPTH-1];
    assign odat = dat[DEPTH-1];

endmodule

// File: tb/tb_s_pipe_reg.sv
// Directed bench for s_pipe_reg (SIZE=8, DEPTH=4) with hand-computed expectations.
module tb_s_pipe_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       ivld;
    logic       irdy;
    logic [7:0] idat;
    logic       ovld;
    logic       ordy;
    logic [7:0] odat;
    logic [2:0] occ;

    int checks = 0;
    int errors = 0;

    s_pipe_reg #(.SIZE(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .ivld  (ivld),
        .irdy  (irdy),
        .idat  (idat),
        .ovld  (ovld),
        .ordy  (ordy),
        .odat  (odat),
        .occ   (occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] bp_occ [7];
        bp_occ = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};

        rst = 1'b1; flush = 1'b0; ivld = 1'b0; idat = 8'h00; ordy = 1'b0;
        #12;
        chk("rst_ovld", 32'(ovld), 32'd0);
        chk("rst_odat", 32'(odat), 32'h00);
        chk("rst_occ",  32'(occ),  32'd0);
        rst = 1'b0;
        #1;
        chk("rst_irdy", 32'(irdy), 32'd1);
        step();

        // Latency: one word through an empty pipe.
        ordy = 1'b1; ivld = 1'b1; idat = 8'hA5;
        step();
        ivld = 1'b0; idat = 8'h00;
        chk("lat_e0", 32'(ovld), 32'd0);
        step(); chk("lat_e1", 32'(ovld), 32'd0);
        step(); chk("lat_e2", 32'(ovld), 32'd0);
        step();
        chk("lat_ovld", 32'(ovld), 32'd1);
        chk("lat_odat", 32'(odat), 32'hA5);
        step();
        chk("lat_gone", 32'(ovld), 32'd0);

        // Streaming 0x01..0x10 at full rate.
        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
                ivld = 1'b1; idat = 8'(c + 1);
            end else begin
                ivld = 1'b0; idat = 8'h00;
            end
            #1;
            if (c < 16) chk("str_irdy", 32'(irdy), 32'd1);
            step();
            if (c >= 3 && c < 19) begin
                chk("str_ovld", 32'(ovld), 32'd1);
                chk("str_odat", 32'(odat), 32'(c - 2));
            end else begin
                chk("str_idle", 32'(ovld), 32'd0);
            end
        end
        chk("str_occ", 32'(occ), 32'd0);

        // Back-pressure with gaps that must collapse.
        ordy = 1'b0;
        for (int c = 0; c < 7; c++) begin
            ivld = (c % 2 == 0);
            idat = (c % 2 == 0) ? 8'(8'h11 * (c / 2 + 1)) : 8'h00;
            step();
            chk("bp_occ", 32'(occ), 32'(bp_occ[c]));
        end
        ivld = 1'b0; idat = 8'h00;
        #1;
        chk("bp_irdy", 32'(irdy), 32'd0);
        chk("bp_ovld", 32'(ovld), 32'd1);
        chk("bp_odat", 32'(odat), 32'h11);
        step(); step();
        chk("bp_hold_odat", 32'(odat), 32'h11);
        chk("bp_hold_occ",  32'(occ),  32'd4);
        ordy = 1'b1;
        #1;
        chk("drain_0", 32'(odat), 32'h11);
        step(); chk("drain_1", 32'(odat), 32'h22); chk("drain_1v", 32'(ovld), 32'd1);
        step(); chk("drain_2", 32'(odat), 32'h33); chk("drain_2v", 32'(ovld), 32'd1);
        step(); chk("drain_3", 32'(odat), 32'h44); chk("drain_3v", 32'(ovld), 32'd1);
        step(); chk("drain_end", 32'(ovld), 32'd0);

        // Full pipe with simultaneous in/out.
        ordy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ivld = 1'b1; idat = 8'(8'h71 + c);
            #1;
            chk("fill_irdy", 32'(irdy), 32'd1);
            step();
        end
        chk("full_occ",  32'(occ),  32'd4);
        chk("full_odat", 32'(odat), 32'h71);
        ordy = 1'b1; ivld = 1'b1; idat = 8'h55;
        #1;
        chk("full_irdy", 32'(irdy), 32'd1);
        step();
        ivld = 1'b0; idat = 8'h00;
        chk("full_occ_kept", 32'(occ), 32'd4);
        chk("full_o1", 32'(odat), 32'h72);
        step(); chk("full_o2", 32'(odat), 32'h73);
        step(); chk("full_o3", 32'(odat), 32'h74);
        step(); chk("full_o4", 32'(odat), 32'h55); chk("full_o4v", 32'(ovld), 32'd1);
        step(); chk("full_end", 32'(ovld), 32'd0); chk("full_end_occ", 32'(occ), 32'd0);

        // Flush with a word pending on the input.
        ordy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ivld = 1'b1; idat = 8'(8'h81 + c);
            step();
        end
        chk("fl_occ3", 32'(occ), 32'd3);
        flush = 1'b1; ivld = 1'b1; idat = 8'h66;
        #1;
        chk("fl_irdy", 32'(irdy), 32'd0);
        step();
        flush = 1'b0; ivld = 1'b0; idat = 8'h00;
        chk("fl_occ",  32'(occ),  32'd0);
        chk("fl_ovld", 32'(ovld), 32'd0);
        ordy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("fl_no_ovld", 32'(ovld), 32'd0);
            chk("fl_odat",    32'(odat), 32'h55);
        end

        // Asynchronous reset with three words in flight, one at the output.
        ordy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ivld = 1'b1; idat = 8'(8'h91 + c);
            step();
        end
        ivld = 1'b0; idat = 8'h00; ordy = 1'b1;
        step();
        ordy = 1'b0;
        chk("pre_rst_occ",  32'(occ),  32'd3);
        chk("pre_rst_odat", 32'(odat), 32'h92);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ovld", 32'(ovld), 32'd0);
        chk("arst_odat", 32'(odat), 32'h00);
        chk("arst_occ",  32'(occ),  32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_irdy", 32'(irdy), 32'd1);
        step();
        chk("arst_idle", 32'(ovld), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
